decoder_scan: RTL and testbench

Parametrised registered N-to-2^N one-hot decoder with a built-in scan sequencer. It is the generalised successor of the fixed 6:64 combinational decoder. The block drives row/column select lines, e.g. display multiplexing or memory bank select. It works either as a direct decoder of an input address or as a self-timed walker across all outputs with a programmable dwell.

---
 rtl/decoder_scan_if.sv | 24 ++
 rtl/decoder_scan.sv | 91 +++++++++
 tb/tb_decoder_scan.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_if.sv
// Select-bus bundle for decoder_scan: control/address inputs toward the
// decoder and the registered one-hot select, index and wrap pulse back.
interface decoder_scan_if #(
  parameter int N       = 6,
  parameter int DWELL_W = 8
);
  logic                 en;
  logic                 mode;
  logic [N-1:0]         a;
  logic [DWELL_W-1:0]   dwell;
  logic [(2**N)-1:0]    y;
  logic [N-1:0]         idx;
  logic                 wrap;

  modport master (
    output en, mode, a, dwell,
    input  y, idx, wrap
  );

  modport slave (
    input  en, mode, a, dwell,
    output y, idx, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a self-timed scan walker that
// holds each output for dwell+1 cycles and pulses wrap on rollover.
module decoder_scan #(
  parameter int N       = 6,
  parameter int DWELL_W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  decoder_scan_if.slave  bus
);

  localparam int               W        = 2**N;
  localparam logic [N-1:0]     IDX_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         y_q, y_d;
  logic [N-1:0]         idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
  logic                 active;

  // Next-state and next-output logic. en dominates mode; scan entry from any
  // other state restarts at index 0 with a cleared dwell counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the branches below can infer a latch.
    state_d = IDLE;
    idx_d   = '0;
    cnt_d   = '0;
    wrap_d  = 1'b0;
    active  = 1'b0;

    if (bus.en) begin
      active = 1'b1;
      if (!bus.mode) begin
        state_d = DIRECT;
        idx_d   = bus.a;
      end else begin
        state_d = SCAN;
        if (state_q == SCAN) begin
          // >= rather than == so a dwell lowered below the running count
          // advances on the next edge instead of stalling a full counter lap.
          if (cnt_q >= bus.dwell) begin
            idx_d  = idx_q + N'(1);
            wrap_d = (idx_q == IDX_LAST);
          end else begin
            idx_d = idx_q;
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end
    end
  end

  // The select is rebuilt from the next index so y == 1 << idx by construction.
  always_comb begin
    y_d = '0;
    if (active) begin
      y_d[idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: a default N=6 instance plus N=3/DWELL_W=1
// and N=1/DWELL_W=1 instances for the small-parameter builds.
module tb_decoder_scan;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  decoder_scan_if #(.N(6), .DWELL_W(8)) bus6 ();
  decoder_scan_if #(.N(3), .DWELL_W(1)) bus3 ();
  decoder_scan_if #(.N(1), .DWELL_W(1)) bus1 ();

  decoder_scan #(.N(6), .DWELL_W(8)) dut6 (.clk(clk), .reset_n(reset_n), .bus(bus6));
  decoder_scan #(.N(3), .DWELL_W(1)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));
  decoder_scan #(.N(1), .DWELL_W(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus6.en = 1'b0; bus6.mode = 1'b0; bus6.a = '0; bus6.dwell = '0;
    bus3.en = 1'b0; bus3.mode = 1'b0; bus3.a = '0; bus3.dwell = '0;
    bus1.en = 1'b0; bus1.mode = 1'b0; bus1.a = '0; bus1.dwell = '0;
    #1;
    tests++;
    if ({bus6.y, bus6.idx, bus6.wrap} !== 71'd0) begin
      fails++;
      $display("FAIL reset6: y=%h idx=%0d wrap=%b, want all zero", bus6.y, bus6.idx, bus6.wrap);
    end
    tests++;
    if ({bus3.y, bus3.idx, bus3.wrap, bus1.y, bus1.idx, bus1.wrap} !== 16'd0) begin
      fails++;
      $display("FAIL reset_small: y3=%h y1=%h, want all zero", bus3.y, bus1.y);
    end
    steps(2);
    reset_n = 1'b1;
    steps(2);
    tests++;
    if ({bus6.y, bus6.idx, bus6.wrap} !== 71'd0) begin
      fails++;
      $display("FAIL post_reset_idle: y=%h idx=%0d, want zero", bus6.y, bus6.idx);
    end
  endtask

  task automatic test_direct();
    logic [5:0]  av [3] = '{6'd0, 6'd5, 6'd63};
    logic [63:0] ev [3] = '{64'h1, 64'h20, 64'h8000_0000_0000_0000};
    bus6.en = 1'b1; bus6.mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus6.a = av[i];
      step();
      tests++;
      if (bus6.y !== ev[i] || bus6.idx !== av[i] || bus6.wrap !== 1'b0) begin
        fails++;
        $display("FAIL direct a=%0d: y=%h idx=%0d wrap=%b, want y=%h idx=%0d wrap=0",
                 av[i], bus6.y, bus6.idx, bus6.wrap, ev[i], av[i]);
      end
    end
  endtask

  task automatic test_scan_dwell0();
    logic [5:0]  exp_idx;
    logic [63:0] exp_y;
    logic        exp_wrap;
    bus6.en = 1'b1; bus6.mode = 1'b1; bus6.dwell = 8'd0;
    for (int k = 0; k <= 65; k++) begin
      step();
      exp_idx  = 6'(k % 64);
      exp_y    = 64'd1 << exp_idx;
      exp_wrap = (k == 64);
      tests++;
      if (bus6.y !== exp_y || bus6.idx !== exp_idx || bus6.wrap !== exp_wrap
          || !$onehot(bus6.y)) begin
        fails++;
        $display("FAIL scan_d0 cycle %0d: y=%h idx=%0d wrap=%b, want y=%h idx=%0d wrap=%b",
                 k, bus6.y, bus6.idx, bus6.wrap, exp_y, exp_idx, exp_wrap);
      end
    end
  endtask

  task automatic test_scan_dwell3();
    logic [5:0] exp_idx;
    bus6.en = 1'b0;
    step();
    bus6.en = 1'b1; bus6.mode = 1'b1; bus6.dwell = 8'd3;
    for (int k = 0; k <= 9; k++) begin
      step();
      exp_idx = 6'(k / 4);
      tests++;
      if (bus6.y !== (64'd1 << exp_idx) || bus6.idx !== exp_idx || bus6.wrap !== 1'b0) begin
        fails++;
        $display("FAIL scan_d3 cycle %0d: y=%h idx=%0d, want idx=%0d", k, bus6.y, bus6.idx, exp_idx);
      end
    end
    // Counter sits at 1 here; lowering dwell below it must advance next edge.
    bus6.dwell = 8'd0;
    step();
    tests++;
    if (bus6.y !== 64'h8 || bus6.idx !== 6'd3) begin
      fails++;
      $display("FAIL dwell_lowered: y=%h idx=%0d, want y=8 idx=3", bus6.y, bus6.idx);
    end
    step();
    tests++;
    if (bus6.y !== 64'h10 || bus6.idx !== 6'd4) begin
      fails++;
      $display("FAIL dwell_lowered_next: y=%h idx=%0d, want y=10 idx=4", bus6.y, bus6.idx);
    end
  endtask

  task automatic test_dwell_max();
    int held_bad;
    bus6.en = 1'b0;
    step();
    bus6.en = 1'b1; bus6.mode = 1'b1; bus6.dwell = 8'd255;
    held_bad = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (bus6.y !== 64'h1 || bus6.idx !== 6'd0) held_bad++;
    end
    tests++;
    if (held_bad != 0) begin
      fails++;
      $display("FAIL dwell_max_hold: %0d of 256 cycles left y[0], want 0", held_bad);
    end
    step();
    tests++;
    if (bus6.y !== 64'h2 || bus6.idx !== 6'd1) begin
      fails++;
      $display("FAIL dwell_max_advance: y=%h idx=%0d, want y=2 idx=1", bus6.y, bus6.idx);
    end
  endtask

  task automatic test_interrupts();
    bus6.en = 1'b0;
    step();
    bus6.en = 1'b1; bus6.mode = 1'b1; bus6.dwell = 8'd0;
    steps(11);
    tests++;
    if (bus6.idx !== 6'd10 || bus6.y !== (64'd1 << 10)) begin
      fails++;
      $display("FAIL int_reach10: y=%h idx=%0d, want idx=10", bus6.y, bus6.idx);
    end
    bus6.en = 1'b0;
    step();
    tests++;
    if ({bus6.y, bus6.idx, bus6.wrap} !== 71'd0) begin
      fails++;
      $display("FAIL int_en_drop: y=%h idx=%0d wrap=%b, want zero", bus6.y, bus6.idx, bus6.wrap);
    end
    bus6.en = 1'b1;
    step();
    tests++;
    if (bus6.y !== 64'h1 || bus6.idx !== 6'd0 || bus6.wrap !== 1'b0) begin
      fails++;
      $display("FAIL int_restart: y=%h idx=%0d wrap=%b, want y=1 idx=0 wrap=0",
               bus6.y, bus6.idx, bus6.wrap);
    end
    steps(5);
    bus6.mode = 1'b0; bus6.a = 6'd42;
    step();
    tests++;
    if (bus6.y !== (64'd1 << 42) || bus6.idx !== 6'd42) begin
      fails++;
      $display("FAIL int_to_direct: y=%h idx=%0d, want y=1<<42 idx=42", bus6.y, bus6.idx);
    end
  endtask

  task automatic test_async_reset();
    bus6.en = 1'b0;
    step();
    bus6.en = 1'b1; bus6.mode = 1'b1; bus6.dwell = 8'd0;
    steps(18);
    tests++;
    if (bus6.idx !== 6'd17) begin
      fails++;
      $display("FAIL areset_setup: idx=%0d, want 17", bus6.idx);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus6.y, bus6.idx, bus6.wrap} !== 71'd0) begin
      fails++;
      $display("FAIL areset_immediate: y=%h idx=%0d wrap=%b, want zero", bus6.y, bus6.idx, bus6.wrap);
    end
    bus6.en = 1'b0;
    step();
    #2;
    reset_n = 1'b1;
    steps(2);
    tests++;
    if ({bus6.y, bus6.idx, bus6.wrap} !== 71'd0) begin
      fails++;
      $display("FAIL areset_release: y=%h idx=%0d, want zero", bus6.y, bus6.idx);
    end
  endtask

  task automatic test_sweep_direct();
    logic [7:0] exp3;
    logic [1:0] exp1;
    bus3.en = 1'b1; bus3.mode = 1'b0;
    bus1.en = 1'b1; bus1.mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus3.a = 3'(i);
      bus1.a = 1'(i);
      step();
      exp3 = 8'd1 << i;
      exp1 = 2'd1 << (i % 2);
      tests++;
      if (bus3.y !== exp3 || bus3.idx !== 3'(i) || bus3.wrap !== 1'b0) begin
        fails++;
        $display("FAIL sweep3_direct a=%0d: y=%h idx=%0d, want y=%h", i, bus3.y, bus3.idx, exp3);
      end
      tests++;
      if (bus1.y !== exp1 || bus1.idx !== 1'(i) || bus1.wrap !== 1'b0) begin
        fails++;
        $display("FAIL sweep1_direct a=%0d: y=%b idx=%0d, want y=%b", i % 2, bus1.y, bus1.idx, exp1);
      end
    end
  endtask

  task automatic test_sweep_scan();
    logic [2:0] e3;
    logic [0:0] e1;
    logic       w3;
    logic       w1;
    int         pulses3;
    int         pulses1;
    pulses3 = 0;
    pulses1 = 0;
    bus3.mode = 1'b1; bus3.dwell = 1'b1;
    bus1.mode = 1'b1; bus1.dwell = 1'b0;
    for (int k = 0; k <= 48; k++) begin
      step();
      e3 = 3'((k / 2) % 8);
      e1 = 1'(k % 2);
      w3 = (k > 0) && (k % 16 == 0);
      w1 = (k > 0) && (k % 2 == 0);
      if (bus3.wrap === 1'b1) pulses3++;
      if (bus1.wrap === 1'b1) pulses1++;
      tests++;
      if (bus3.idx !== e3 || bus3.y !== (8'd1 << e3) || bus3.wrap !== w3) begin
        fails++;
        $display("FAIL sweep3_scan cycle %0d: y=%h idx=%0d wrap=%b, want idx=%0d wrap=%b",
                 k, bus3.y, bus3.idx, bus3.wrap, e3, w3);
      end
      tests++;
      if (bus1.idx !== e1 || bus1.y !== (2'd1 << e1) || bus1.wrap !== w1) begin
        fails++;
        $display("FAIL sweep1_scan cycle %0d: y=%b idx=%0d wrap=%b, want idx=%0d wrap=%b",
                 k, bus1.y, bus1.idx, bus1.wrap, e1, w1);
      end
    end
    tests++;
    if (pulses3 != 3 || pulses1 != 24) begin
      fails++;
      $display("FAIL sweep_wrap_count: n3=%0d n1=%0d, want 3 and 24", pulses3, pulses1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_direct();
    test_scan_dwell0();
    test_scan_dwell3();
    test_dwell_max();
    test_interrupts();
    test_async_reset();
    test_sweep_direct();
    test_sweep_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
